// File: rtl/clock_divider_gen_if.sv
// Control/status bundle for clock_divider_gen: enable, phase restart,
// divisor reload, and the tick / square-wave / debug outputs.
interface clock_divider_gen_if #(
    parameter int CNT_WIDTH = 21
);
    logic                 en;
    logic                 restart;
    logic [CNT_WIDTH-1:0] div_in;
    logic                 div_load;
    logic                 tick;
    logic                 sq_out;
    logic                 div_busy;
    logic [CNT_WIDTH-1:0] cnt_out;

    modport master (
        output en, restart, div_in, div_load,
        input  tick, sq_out, div_busy, cnt_out
    );

    modport slave (
        input  en, restart, div_in, div_load,
        output tick, sq_out, div_busy, cnt_out
    );
endinterface

// File: rtl/clock_divider_gen.sv
// Runtime-programmable clock-enable generator: one-cycle tick every DIV+1
// enabled cycles plus a 50% square wave; divisor reloads at period boundaries.
module clock_divider_gen #(
    parameter int CNT_WIDTH   = 21,
    parameter int DEFAULT_DIV = 500000
) (
    input logic                clk_in,
    input logic                rst_n,
    clock_divider_gen_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] RESET_DIV = CNT_WIDTH'(DEFAULT_DIV);

    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic [CNT_WIDTH-1:0] div_active_reg, div_active_next;
    logic [CNT_WIDTH-1:0] div_pend_reg, div_pend_next;
    logic                 pend_v_reg, pend_v_next;
    logic                 tick_reg, tick_next;
    logic                 sq_out_reg, sq_out_next;
    logic                 boundary;

    always_comb begin
        count_next      = count_reg;
        div_active_next = div_active_reg;
        div_pend_next   = div_pend_reg;
        pend_v_next     = pend_v_reg;
        tick_next       = 1'b0;
        sq_out_next     = sq_out_reg;
        boundary        = 1'b0;

        if (bus.restart) begin
            count_next  = '0;
            sq_out_next = 1'b0;
            boundary    = 1'b1;
        end else if (bus.en) begin
            if (count_reg == div_active_reg) begin
                count_next  = '0;
                tick_next   = 1'b1;
                sq_out_next = ~sq_out_reg;
                boundary    = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end

        // Apply the divisor that was pending before this edge; a load on the
        // same edge is captured afterwards and waits for the next boundary.
        if (boundary && pend_v_reg) begin
            div_active_next = div_pend_reg;
            pend_v_next     = 1'b0;
        end
        if (bus.div_load) begin
            div_pend_next = bus.div_in;
            pend_v_next   = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_reg      <= '0;
            div_active_reg <= RESET_DIV;
            div_pend_reg   <= '0;
            pend_v_reg     <= 1'b0;
            tick_reg       <= 1'b0;
            sq_out_reg     <= 1'b0;
        end else begin
            count_reg      <= count_next;
            div_active_reg <= div_active_next;
            div_pend_reg   <= div_pend_next;
            pend_v_reg     <= pend_v_next;
            tick_reg       <= tick_next;
            sq_out_reg     <= sq_out_next;
        end
    end

    assign bus.tick     = tick_reg;
    assign bus.sq_out   = sq_out_reg;
    assign bus.div_busy = pend_v_reg;
    assign bus.cnt_out  = count_reg;
endmodule

// File: tb/tb_clock_divider_gen.sv
// Directed bench for clock_divider_gen (4-bit counter, reset divisor 4);
// every cycle compares {tick, sq_out, div_busy, cnt_out} to hand-derived values.
module tb_clock_divider_gen;
    localparam int CW = 4;

    logic clk_in = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    clock_divider_gen_if #(.CNT_WIDTH(CW)) dif ();

    clock_divider_gen #(.CNT_WIDTH(CW), .DEFAULT_DIV(4)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (dif.slave)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {tick,sq,busy,cnt}=%h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: {tick,sq,busy,cnt}=%h", tag, obs);
        end
    endtask

    // Advance one clock edge, then compare the registered outputs 1 ns later.
    task automatic cyc(input string tag, input int c, input bit t, input bit s, input bit b);
        logic [CW-1:0] c_l;
        @(posedge clk_in);
        #1;
        c_l = c[CW-1:0];
        check_val(tag, {25'd0, dif.tick, dif.sq_out, dif.div_busy, dif.cnt_out},
                       {25'd0, t, s, b, c_l});
    endtask

    initial begin
        rst_n = 1'b0; dif.en = 1'b1; dif.restart = 1'b0;
        dif.div_load = 1'b0; dif.div_in = '0;

        // Reset holds every output at zero even with en high
        repeat (3) cyc("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Default divisor 4: ticks every 5th edge, sq period 10
        for (int k = 1; k <= 21; k++)
            cyc("div4_run", k % 5, (k % 5) == 0, ((k / 5) % 2) == 1, 0);

        // Load 2 at count=1: current period still 5 long, then 3-cycle periods
        dif.div_load = 1'b1; dif.div_in = 4'd2;
        cyc("ld2_e22", 2, 0, 0, 1);
        dif.div_load = 1'b0;
        cyc("ld2_e23", 3, 0, 0, 1);
        cyc("ld2_e24", 4, 0, 0, 1);
        cyc("ld2_wrap", 0, 1, 1, 0);
        cyc("div2_e26", 1, 0, 1, 0);
        cyc("div2_e27", 2, 0, 1, 0);
        cyc("div2_wrap1", 0, 1, 0, 0);
        cyc("div2_e29", 1, 0, 0, 0);
        cyc("div2_e30", 2, 0, 0, 0);
        cyc("div2_wrap2", 0, 1, 1, 0);

        // Back to div 4, then stall 7 cycles mid-period: tick interval 12
        dif.div_load = 1'b1; dif.div_in = 4'd4;
        cyc("ld4_e32", 1, 0, 1, 1);
        dif.div_load = 1'b0;
        cyc("ld4_e33", 2, 0, 1, 1);
        cyc("ld4_wrap", 0, 1, 0, 0);
        cyc("div4_e35", 1, 0, 0, 0);
        cyc("div4_e36", 2, 0, 0, 0);
        dif.en = 1'b0;
        for (int k = 0; k < 7; k++) cyc("hold", 2, 0, 0, 0);
        dif.en = 1'b1;
        cyc("resume_e44", 3, 0, 0, 0);
        cyc("resume_e45", 4, 0, 0, 0);
        cyc("stretch_wrap", 0, 1, 1, 0);

        // Restart at count=3 with pending div 1
        cyc("pre_rs_e47", 1, 0, 1, 0);
        dif.div_load = 1'b1; dif.div_in = 4'd1;
        cyc("pre_rs_e48", 2, 0, 1, 1);
        dif.div_load = 1'b0;
        cyc("pre_rs_e49", 3, 0, 1, 1);
        dif.restart = 1'b1;
        cyc("restart", 0, 0, 0, 0);
        dif.restart = 1'b0;
        cyc("div1_e51", 1, 0, 0, 0);
        cyc("div1_wrap1", 0, 1, 1, 0);
        cyc("div1_e53", 1, 0, 1, 0);
        cyc("div1_wrap2", 0, 1, 0, 0);

        // Loads on a wrap edge stay pending; a second load overwrites
        cyc("div1_e55", 1, 0, 0, 0);
        dif.div_load = 1'b1; dif.div_in = 4'd7;
        cyc("ld_on_wrap", 0, 1, 1, 1);
        dif.div_in = 4'd3;
        cyc("ld_overwrite", 1, 0, 1, 1);
        dif.div_load = 1'b0;
        cyc("apply3_wrap", 0, 1, 0, 0);
        cyc("div3_e59", 1, 0, 0, 0);
        cyc("div3_e60", 2, 0, 0, 0);
        cyc("div3_e61", 3, 0, 0, 0);
        cyc("div3_wrap", 0, 1, 1, 0);

        // Divisor 0: tick stays high, sq toggles every cycle
        dif.div_load = 1'b1; dif.div_in = 4'd0;
        cyc("ld0_e63", 1, 0, 1, 1);
        dif.div_load = 1'b0;
        cyc("ld0_e64", 2, 0, 1, 1);
        cyc("ld0_e65", 3, 0, 1, 1);
        cyc("apply0_wrap", 0, 1, 0, 0);
        cyc("div0_a", 0, 1, 1, 0);
        cyc("div0_b", 0, 1, 0, 0);
        cyc("div0_c", 0, 1, 1, 0);
        cyc("div0_d", 0, 1, 0, 0);

        // Maximum divisor 15: count reaches 15 and wraps to 0
        dif.div_load = 1'b1; dif.div_in = 4'd15;
        cyc("ld15_on_wrap", 0, 1, 1, 1);
        dif.div_load = 1'b0;
        cyc("apply15_wrap", 0, 1, 0, 0);
        for (int k = 1; k <= 15; k++) cyc("div15_run", k, 0, 0, 0);
        cyc("div15_wrap", 0, 1, 1, 0);

        // Reset with a pending load, en, restart and div_load all active
        dif.div_load = 1'b1; dif.div_in = 4'd2;
        cyc("pend_e89", 1, 0, 1, 1);
        rst_n = 1'b0; dif.restart = 1'b1; dif.div_in = 4'd5;
        cyc("reset_override", 0, 0, 0, 0);
        rst_n = 1'b1; dif.restart = 1'b0; dif.div_load = 1'b0;
        for (int k = 1; k <= 4; k++) cyc("post_rst", k, 0, 0, 0);
        cyc("post_rst_wrap", 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
